// File: rtl/store_drain_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// store_drain_buffer: FIFO of retired stores, drained one at a time to the D-cache.
// Revision: 1.0
//------------------------------------------------------------------------------
module store_drain_buffer #(
    parameter int  N_IN     = 2,
    parameter int  DEPTH    = 4,
    parameter int  XLEN     = 32,
    parameter int  DEPTH_SQ = 8,
    localparam int POS_W    = $clog2(DEPTH_SQ) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_IN-1:0]                ret_valid,
    input  logic [N_IN-1:0][XLEN-1:0]      ret_addr,
    input  logic [N_IN-1:0][XLEN-1:0]      ret_data,
    input  logic [N_IN-1:0][1:0]           ret_size,
    input  logic [N_IN-1:0][POS_W-1:0]     ret_pos,
    output logic                           ret_stall,
    output logic                           wr_req,
    output logic [XLEN-1:0]                wr_addr,
    output logic [XLEN-1:0]                wr_data,
    output logic [3:0]                     wr_mask,
    input  logic                           wr_ack,
    output logic                           done_valid,
    output logic [XLEN-1:0]                done_addr,
    output logic [POS_W-1:0]               done_pos,
    output logic                           overflow
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam int               PTR_W   = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] N_IN_C  = PTR_W'(N_IN);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic [POS_W-1:0] pos_q  [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             done_valid_q;
    logic [XLEN-1:0]  done_addr_q;
    logic [POS_W-1:0] done_pos_q;
    logic             overflow_q;

    logic [PTR_W-1:0]            used, free, used_d, n_push;
    logic [N_IN-1:0]             slot_acc;
    logic [N_IN-1:0][IDX_W-1:0]  slot_idx;
    logic                        drop, pop;
    logic [IDX_W-1:0]            head;
    logic [1:0]                  lane;
    logic [3:0]                  mask;

    // Extra MSB on the pointers makes the difference equal the occupancy, including full.
    assign used      = wr_ptr_q - rd_ptr_q;
    assign free      = DEPTH_C - used;
    assign ret_stall = (free < N_IN_C);
    assign head      = rd_ptr_q[IDX_W-1:0];

    // Compact valid slots onto the tail; anything past the free space is lost.
    always_comb begin
        n_push   = '0;
        drop     = 1'b0;
        slot_acc = '0;
        slot_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            slot_idx[i] = IDX_W'(wr_ptr_q + n_push);
            if (ret_valid[i]) begin
                if (n_push < free) begin
                    slot_acc[i] = 1'b1;
                    n_push      = n_push + ONE_C;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign pop      = (state_q != S_IDLE) && wr_ack;
    assign wr_ptr_d = wr_ptr_q + n_push;
    assign rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    assign used_d   = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_IN; i++) begin
            if (slot_acc[i]) begin
                addr_q[slot_idx[i]] <= ret_addr[i];
                data_q[slot_idx[i]] <= ret_data[i];
                size_q[slot_idx[i]] <= ret_size[i];
                pos_q[slot_idx[i]]  <= ret_pos[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_valid_q <= 1'b0;
            done_addr_q  <= '0;
            done_pos_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            done_valid_q <= pop;
            if (pop) begin
                done_addr_q <= addr_q[head];
                done_pos_q  <= pos_q[head];
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Next state looks at post-update occupancy so a fresh entry issues the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (used_d != '0) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (wr_ack) begin
                    state_d = (used_d != '0) ? S_ISSUE : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane = 2'b00;
        mask = 4'b1111;
        case (size_q[head])
            SZ_BYTE: begin
                lane = addr_q[head][1:0];
                mask = 4'b0001 << lane;
            end
            SZ_HALF: begin
                lane = {addr_q[head][1], 1'b0};
                mask = 4'b0011 << lane;
            end
            default: begin
                lane = 2'b00;
                mask = 4'b1111;
            end
        endcase
        wr_req  = (state_q != S_IDLE);
        wr_addr = wr_req ? {addr_q[head][XLEN-1:2], 2'b00} : '0;
        wr_data = wr_req ? (data_q[head] << {lane, 3'b000}) : '0;
        wr_mask = wr_req ? mask : 4'b0000;
    end

    assign done_valid = done_valid_q;
    assign done_addr  = done_addr_q;
    assign done_pos   = done_pos_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_store_drain_buffer: directed vector table plus multi-cycle stall/overflow/reset sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_store_drain_buffer;

    logic                 clock;
    logic                 reset;
    logic [1:0]           ret_valid;
    logic [1:0][31:0]     ret_addr;
    logic [1:0][31:0]     ret_data;
    logic [1:0][1:0]      ret_size;
    logic [1:0][3:0]      ret_pos;
    logic                 ret_stall;
    logic                 wr_req;
    logic [31:0]          wr_addr;
    logic [31:0]          wr_data;
    logic [3:0]           wr_mask;
    logic                 wr_ack;
    logic                 done_valid;
    logic [31:0]          done_addr;
    logic [3:0]           done_pos;
    logic                 overflow;

    int total = 0;
    int bad   = 0;

    store_drain_buffer #(.N_IN(2), .DEPTH(4), .XLEN(32), .DEPTH_SQ(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .ret_valid  (ret_valid),
        .ret_addr   (ret_addr),
        .ret_data   (ret_data),
        .ret_size   (ret_size),
        .ret_pos    (ret_pos),
        .ret_stall  (ret_stall),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wr_ack     (wr_ack),
        .done_valid (done_valid),
        .done_addr  (done_addr),
        .done_pos   (done_pos),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]       v;
        logic [1:0][31:0] a;
        logic [1:0][31:0] d;
        logic [1:0][1:0]  s;
        logic [1:0][3:0]  p;
        logic             ack;
        logic             e_req;
        logic [31:0]      e_addr;
        logic [31:0]      e_data;
        logic [3:0]       e_mask;
        logic             e_done;
        logic [31:0]      e_daddr;
        logic [3:0]       e_dpos;
        logic             e_stall;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(
        input logic [1:0] v,
        input logic [31:0] a0, input logic [31:0] d0, input logic [1:0] s0, input logic [3:0] p0,
        input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] s1, input logic [3:0] p1,
        input logic req, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
        input logic done, input logic [31:0] daddr, input logic [3:0] dpos);
        vec_t r;
        r.v = v;
        r.a[0] = a0; r.d[0] = d0; r.s[0] = s0; r.p[0] = p0;
        r.a[1] = a1; r.d[1] = d1; r.s[1] = s1; r.p[1] = p1;
        r.ack = 1'b1;
        r.e_req = req; r.e_addr = addr; r.e_data = data; r.e_mask = mask;
        r.e_done = done; r.e_daddr = daddr; r.e_dpos = dpos;
        r.e_stall = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ret_valid = '0;
        ret_addr  = '0;
        ret_data  = '0;
        ret_size  = '0;
        ret_pos   = '0;
    endtask

    task automatic put(input int slot, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [3:0] p);
        ret_valid[slot] = 1'b1;
        ret_addr[slot]  = a;
        ret_data[slot]  = d;
        ret_size[slot]  = s;
        ret_pos[slot]   = p;
    endtask

    task automatic chk_done(input string name, input logic exp_v, input logic [3:0] exp_p);
        chk({name, "_done_valid"}, {31'b0, done_valid}, {31'b0, exp_v});
        if (exp_v) chk({name, "_done_pos"}, {28'b0, done_pos}, {28'b0, exp_p});
    endtask

    initial begin
        // Columns: valid, slot0 {addr,data,size,pos}, slot1 {...}, then expected after the edge.
        vecs[0]  = mk(2'b01, 32'h100, 32'hDEADBEEF, 2'd2, 4'd3, 0, 0, 0, 0,
                      1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
        vecs[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h100, 4'd3);
        vecs[2]  = mk(2'b01, 32'h203, 32'h5A, 2'd0, 4'd5, 0, 0, 0, 0,
                      1, 32'h200, 32'h5A000000, 4'b1000, 0, 0, 0);
        vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h203, 4'd5);
        vecs[4]  = mk(2'b11, 32'h12, 32'hBEEF, 2'd1, 4'd1, 32'h40, 32'h12345678, 2'd2, 4'd2,
                      1, 32'h10, 32'hBEEF0000, 4'b1100, 0, 0, 0);
        vecs[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 32'h40, 32'h12345678, 4'b1111, 1, 32'h12, 4'd1);
        vecs[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h40, 4'd2);
        vecs[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(2'b10, 0, 0, 0, 0, 32'h13, 32'hA5C3, 2'd1, 4'd6,
                      1, 32'h10, 32'hA5C30000, 4'b1100, 0, 0, 0);
        vecs[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h13, 4'd6);
        vecs[10] = mk(2'b01, 32'h46, 32'hCAFEF00D, 2'd2, 4'd7, 0, 0, 0, 0,
                      1, 32'h44, 32'hCAFEF00D, 4'b1111, 0, 0, 0);
        vecs[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h46, 4'd7);
        vecs[12] = mk(2'b01, 32'h201, 32'h77, 2'd0, 4'd9, 0, 0, 0, 0,
                      1, 32'h200, 32'h00007700, 4'b0010, 0, 0, 0);
        vecs[13] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 32'h201, 4'd9);

        reset  = 1'b1;
        wr_ack = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_wr_req", {31'b0, wr_req}, 32'h0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_wr_mask", {28'b0, wr_mask}, 32'h0);
        chk("rst_done_valid", {31'b0, done_valid}, 32'h0);
        chk("rst_done_addr", done_addr, 32'h0);
        chk("rst_done_pos", {28'b0, done_pos}, 32'h0);
        chk("rst_overflow", {31'b0, overflow}, 32'h0);
        chk("rst_stall", {31'b0, ret_stall}, 32'h0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 14; k++) begin
            ret_valid = vecs[k].v;
            ret_addr  = vecs[k].a;
            ret_data  = vecs[k].d;
            ret_size  = vecs[k].s;
            ret_pos   = vecs[k].p;
            wr_ack    = vecs[k].ack;
            tick();
            chk($sformatf("v%0d_wr_req", k), {31'b0, wr_req}, {31'b0, vecs[k].e_req});
            if (vecs[k].e_req) begin
                chk($sformatf("v%0d_wr_addr", k), wr_addr, vecs[k].e_addr);
                chk($sformatf("v%0d_wr_data", k), wr_data, vecs[k].e_data);
                chk($sformatf("v%0d_wr_mask", k), {28'b0, wr_mask}, {28'b0, vecs[k].e_mask});
            end
            chk($sformatf("v%0d_done_valid", k), {31'b0, done_valid}, {31'b0, vecs[k].e_done});
            if (vecs[k].e_done) begin
                chk($sformatf("v%0d_done_addr", k), done_addr, vecs[k].e_daddr);
                chk($sformatf("v%0d_done_pos", k), {28'b0, done_pos}, {28'b0, vecs[k].e_dpos});
            end
            chk($sformatf("v%0d_stall", k), {31'b0, ret_stall}, {31'b0, vecs[k].e_stall});
        end

        // Fill with the cache refusing writes, overrun it, hold 5 cycles, then drain.
        idle_inputs();
        wr_ack = 1'b0;
        put(0, 32'h400, 32'hA0, 2'd2, 4'd10);
        put(1, 32'h404, 32'hA1, 2'd2, 4'd11);
        tick();
        chk("fill1_stall", {31'b0, ret_stall}, 32'h0);
        chk("fill1_wr_addr", wr_addr, 32'h400);
        idle_inputs();
        put(0, 32'h408, 32'hA2, 2'd2, 4'd12);
        put(1, 32'h40C, 32'hA3, 2'd2, 4'd13);
        tick();
        chk("fill2_stall", {31'b0, ret_stall}, 32'h1);
        chk("fill2_overflow", {31'b0, overflow}, 32'h0);
        idle_inputs();
        put(0, 32'h500, 32'hB0, 2'd2, 4'd14);
        put(1, 32'h504, 32'hB1, 2'd2, 4'd15);
        tick();
        chk("ovf_overflow", {31'b0, overflow}, 32'h1);
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("hold%0d_wr_req", c), {31'b0, wr_req}, 32'h1);
            chk($sformatf("hold%0d_wr_addr", c), wr_addr, 32'h400);
            chk($sformatf("hold%0d_wr_data", c), wr_data, 32'hA0);
            chk($sformatf("hold%0d_wr_mask", c), {28'b0, wr_mask}, 32'hF);
            chk($sformatf("hold%0d_stall", c), {31'b0, ret_stall}, 32'h1);
            chk($sformatf("hold%0d_done", c), {31'b0, done_valid}, 32'h0);
        end
        wr_ack = 1'b1;
        tick();
        chk_done("drain0", 1'b1, 4'd10);
        // One slot free is still fewer than the two presented per cycle.
        chk("drain0_stall", {31'b0, ret_stall}, 32'h1);
        chk("drain0_wr_addr", wr_addr, 32'h404);
        tick();
        chk_done("drain1", 1'b1, 4'd11);
        chk("drain1_stall", {31'b0, ret_stall}, 32'h0);
        chk("drain1_wr_addr", wr_addr, 32'h408);
        tick();
        chk_done("drain2", 1'b1, 4'd12);
        chk("drain2_wr_addr", wr_addr, 32'h40C);
        tick();
        chk_done("drain3", 1'b1, 4'd13);
        chk("drain3_done_addr", done_addr, 32'h40C);
        chk("drain3_wr_req", {31'b0, wr_req}, 32'h0);
        tick();
        chk_done("drain4", 1'b0, 4'd0);
        chk("drain4_overflow", {31'b0, overflow}, 32'h1);

        // Reset in the middle of a refused write.
        wr_ack = 1'b0;
        put(0, 32'h600, 32'h66, 2'd2, 4'd1);
        tick();
        idle_inputs();
        tick();
        chk("wait_wr_req", {31'b0, wr_req}, 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_wr_req", {31'b0, wr_req}, 32'h0);
        chk("arst_overflow", {31'b0, overflow}, 32'h0);
        chk("arst_stall", {31'b0, ret_stall}, 32'h0);
        @(posedge clock);
        #2;
        reset  = 1'b0;
        wr_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post%0d_done", c), {31'b0, done_valid}, 32'h0);
            chk($sformatf("post%0d_wr_req", c), {31'b0, wr_req}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_drain_buffer.md
STORE_DRAIN_BUFFER -- requirements
Module: store_drain_buffer

Interface
REQ-001 Parameter N_IN, default 2 (`N_WAY), meaning retired-store slots presented per cycle.
REQ-002 Parameter DEPTH, default 4, meaning buffer entries; power of two, >= N_IN.
REQ-003 Parameter XLEN, default 32 (`XLEN), meaning address and data width.
REQ-004 One clock; reset is asynchronous and active-high; the ports are named clock and reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 ret_valid  input  N_IN  per-slot retired-store valid.
REQ-008 ret_addr  input  N_IN x XLEN  store byte address.
REQ-009 ret_data  input  N_IN x XLEN  store data, right-aligned.
REQ-010 ret_size  input  N_IN x 2  size: BYTE=0, HALF=1, WORD=2.
REQ-011 ret_pos  input  N_IN x clog2(DEPTH_SQ)+1  store-queue position (1-based), carried through.
REQ-012 ret_stall  output  1  set when free entries < N_IN.
REQ-013 wr_req  output  1  D-cache write request.
REQ-014 wr_addr  output  XLEN  word-aligned write address ({addr[XLEN-1:2],2'b00}).
REQ-015 wr_data  output  XLEN  lane-shifted write data.
REQ-016 wr_mask  output  4  byte-enable mask.
REQ-017 wr_ack  input  1  D-cache accepted the write this cycle (hit, or miss fill complete).
REQ-018 done_valid  output  1  one-cycle completion pulse, fed back to the store queue.
REQ-019 done_addr  output  XLEN  original byte address of the completed store.
REQ-020 done_pos  output  clog2(DEPTH_SQ)+1  ret_pos of the completed store.
REQ-021 overflow  output  1  sticky error flag.

Function
REQ-022 Enqueue: slots are accepted in ascending slot index order; valid slots are compacted into consecutive FIFO entries at the tail in the same cycle.
REQ-023 Enqueue with ret_stall high: slots beyond the free space are dropped and overflow is set; overflow stays set until reset.
REQ-024 Mask generation: BYTE -> 4'b0001<<addr[1:0]; HALF -> 4'b0011<<{addr[1],1'b0}; WORD -> 4'b1111. The data lane shift uses the same amount, in bytes.
REQ-025 Misaligned HALF (addr[0]=1) and misaligned WORD (addr[1:0]!=0) accesses are treated as aligned: low address bits are ignored for the shift.
REQ-026 FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when the buffer is non-empty.
- ISSUE drives wr_req=1 with the head entry. On wr_ack the state goes to IDLE, or stays in ISSUE if another entry is present; without wr_ack it goes to WAIT.
- WAIT holds wr_req=1 and all wr_* outputs stable until wr_ack, then behaves as an acked ISSUE.
REQ-027 wr_req is a registered decision: an entry enqueued in cycle N can drive wr_req no earlier than cycle N+1.
REQ-028 With wr_ack tied high, throughput is one store per cycle.
REQ-029 On wr_ack the head is popped and done_valid/done_addr/done_pos are registered, asserting in the next cycle for exactly one cycle.
REQ-030 Simultaneous pop and push in one cycle: free count = old free + 1 - pushes; ret_stall uses the registered count before that cycle.
REQ-031 Pointers are clog2(DEPTH)+1 bits and wrap modulo DEPTH.
- Full: MSBs differ and the remaining bits are equal.
- Empty: the pointers are equal.
REQ-032 Stores drain strictly in FIFO order; no merging or reordering.
REQ-033 There is no flush input: retired stores are architectural and survive branch hazards.

Reset
REQ-034 Asynchronous reset sets:
- state=IDLE;
- pointers=0, count=0;
- wr_req=0, wr_addr=0, wr_data=0, wr_mask=0;
- done_valid=0, done_addr=0, done_pos=0;
- overflow=0;
- ret_stall=0 when DEPTH>=N_IN.
REQ-035 Reset asserted mid-WAIT abandons the pending write; wr_req drops asynchronously and no done pulse is produced.

Verification
REQ-036 Scenario: one WORD store at addr 0x100, data 0xDEADBEEF, pos 3, wr_ack=1 -> next cycle wr_req=1, wr_addr=0x100, mask=1111, data=0xDEADBEEF; one cycle later done_valid=1, done_pos=3.
REQ-037 Scenario: BYTE store at addr 0x203, data 0x5A -> wr_addr=0x200, mask=1000, wr_data=0x5A000000.
REQ-038 Scenario: two slots valid in one cycle (HALF at 0x12, data 0xBEEF; WORD at 0x40), wr_ack=1 -> two consecutive writes.
- First write: mask 1100, data 0xBEEF0000.
- Second write: mask 1111 at 0x40.
- Two done pulses follow in slot order.
REQ-039 Scenario: wr_ack held 0 for 5 cycles with 4 stores queued -> wr_* outputs stable for those 5 cycles, ret_stall=1, no done pulse; the first ack then drains 1 entry and ret_stall drops the cycle after that.
REQ-040 Scenario: fill to DEPTH, then present 2 valid slots -> both dropped, overflow=1 sticky, and FIFO contents drain unchanged.
REQ-041 Scenario: reset asserted mid-WAIT -> wr_req=0 in the same cycle, FIFO empty, and no done_valid after release.
